// File: rtl/hce_loader_pkg.sv
// Shared definitions for the hce_stream_loader slice.
//   loader_state_t : frame-parser FSM states
//   CMD_KEY/CMD_DATA : frame command byte values
//   KEY_BYTES      : key frame payload length in bytes
package hce_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEY    = 3'd1,
    COMMIT = 3'd2,
    DATA   = 3'd3,
    DROP   = 3'd4
  } loader_state_t;

  localparam logic [7:0] CMD_KEY  = 8'h01;
  localparam logic [7:0] CMD_DATA = 8'h02;
  localparam int         KEY_BYTES = 5;

endpackage

// File: rtl/hce_loader_fifo.sv
// Synchronous FIFO with a registered read port.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter. DEPTH must be a power of two >= 2.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, wr_data : write request and data (ignored while full)
//   pop        : read request (ignored while empty); rd_data valid next cycle
//   rd_data    : registered read data
//   full, empty: occupancy flags, combinational from the pointers
module hce_loader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/hce_stream_loader.sv
// Byte-stream front end for hybrid_chaotic_encryption.
// Parses framed bytes (command byte + payload) into key loads and plaintext,
// buffers plaintext in a FIFO and paces it to the core, which has no
// backpressure. A new key is applied only once all plaintext queued under
// the previous key has been issued.
// Optional feature macro: HCE_LOADER_STATS_EN enables stat_bytes/stat_drops
// counters; when undefined both ports are tied to zero.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_ready never depends on in_valid, and the source holds in_byte/in_last
// stable while in_valid is high and in_ready is low.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_byte/in_valid/in_last/in_ready : framed input stream
//   key, key_valid_in     : key to core and one-cycle commit strobe
//   plaintext, plaintext_valid_in : byte to core and one-cycle strobe
//   key_loaded            : a key has been committed since reset
//   frame_err             : one-cycle pulse on a malformed frame
//   stat_bytes, stat_drops: saturating issue / drop counters
//   dbg_state             : current parser FSM state
module hce_stream_loader
  import hce_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEY_WIDTH  = 4*DATA_WIDTH+1,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_byte,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [KEY_WIDTH-1:0]  key,
  output logic                  key_valid_in,
  output logic [DATA_WIDTH-1:0] plaintext,
  output logic                  plaintext_valid_in,
  output logic                  key_loaded,
  output logic                  frame_err,
  output logic [15:0]           stat_bytes,
  output logic [15:0]           stat_drops,
  output loader_state_t         dbg_state
);

  localparam int         GW        = (GAP > 0) ? $clog2(GAP+1) : 1;
  localparam logic [2:0] KCNT_LAST = 3'(KEY_BYTES-1);

  loader_state_t         state, state_nx;
  logic [2:0]            kcnt, kcnt_nx;
  logic [KEY_WIDTH-1:0]  shadow;
  logic                  shadow_clr, shadow_wr;
  logic                  ready_en;
  logic                  rdy_state;
  logic                  accept;
  logic                  push, commit, err;
  logic                  pop, pop_q;
  logic [GW-1:0]         gap_cnt;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  assign dbg_state = state;

  // ready_en keeps in_ready low through reset and rises one cycle after it.
  assign rdy_state = (state == COMMIT) ? 1'b0 :
                     (state == DATA)   ? !fifo_full : 1'b1;
  assign in_ready  = ready_en && rdy_state;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      kcnt     <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nx;
      kcnt     <= kcnt_nx;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    kcnt_nx    = kcnt;
    push       = 1'b0;
    commit     = 1'b0;
    err        = 1'b0;
    shadow_clr = 1'b0;
    shadow_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            // A bare command byte closes an empty frame; only a key
            // command with no payload counts as malformed.
            err = (in_byte == DATA_WIDTH'(CMD_KEY));
          end else if (in_byte == DATA_WIDTH'(CMD_KEY)) begin
            state_nx   = KEY;
            kcnt_nx    = '0;
            shadow_clr = 1'b1;
          end else if (in_byte == DATA_WIDTH'(CMD_DATA)) begin
            state_nx = DATA;
          end else begin
            state_nx = DROP;
            err      = 1'b1;
          end
        end
      end
      KEY: begin
        if (accept) begin
          shadow_wr = 1'b1;
          if (kcnt == KCNT_LAST) begin
            if (in_last) state_nx = COMMIT;
            else begin
              err      = 1'b1;
              state_nx = DROP;
            end
          end else if (in_last) begin
            err        = 1'b1;
            shadow_clr = 1'b1;
            state_nx   = IDLE;
          end else begin
            kcnt_nx = kcnt + 3'd1;
          end
        end
      end
      COMMIT: begin
        // Before the first key nothing has been issued, so buffered
        // plaintext is meant for this key and must not block it.
        if (!key_loaded || (fifo_empty && !pop_q)) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end
      end
      DATA: begin
        if (accept) begin
          push = 1'b1;
          if (in_last) state_nx = IDLE;
        end
      end
      DROP: begin
        if (accept && in_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shadow key assembly: payload byte 0 supplies only precision_sel,
  // bytes 1..4 fill k, y0, alpha, mu from high to low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (shadow_clr) begin
      shadow <= '0;
    end else if (shadow_wr) begin
      if (kcnt == 3'd0) shadow[KEY_WIDTH-1] <= in_byte[0];
      else shadow[(KEY_BYTES-1-int'(kcnt))*DATA_WIDTH +: DATA_WIDTH] <= in_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key          <= '0;
      key_valid_in <= 1'b0;
      key_loaded   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      key_valid_in <= commit;
      frame_err    <= err;
      if (commit) begin
        key        <= shadow;
        key_loaded <= 1'b1;
      end
    end
  end

  hce_loader_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (in_byte),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Issue side: pop, then one cycle for the FIFO read register and one for
  // the output register. pop_q marks a byte still in flight to the core.
  assign pop = !fifo_empty && key_loaded && (gap_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q              <= 1'b0;
      gap_cnt            <= '0;
      plaintext          <= '0;
      plaintext_valid_in <= 1'b0;
    end else begin
      pop_q              <= pop;
      plaintext_valid_in <= pop_q;
      if (pop_q) plaintext <= fifo_rd_data;
      if (pop) gap_cnt <= GW'(GAP);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
    end
  end

`ifdef HCE_LOADER_STATS_EN
  logic [15:0] bytes_q, drops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_q <= '0;
      drops_q <= '0;
    end else begin
      if (plaintext_valid_in && (bytes_q != 16'hFFFF)) bytes_q <= bytes_q + 16'd1;
      if (frame_err && (drops_q != 16'hFFFF)) drops_q <= drops_q + 16'd1;
    end
  end

  assign stat_bytes = bytes_q;
  assign stat_drops = drops_q;
`else
  assign stat_bytes = '0;
  assign stat_drops = '0;
`endif

endmodule
